// File: rtl/uart_rx_fifo_writer_if.sv
// FIFO write-port bundle between the UART receiver (master) and the async FIFO write side (slave).
interface uart_rx_fifo_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  Write;
  logic [DATA_WIDTH-1:0] Din;
  logic                  Full;

  modport master (output Write, output Din, input Full);
  modport slave  (input Write, input Din, output Full);
endinterface

// File: rtl/uart_rx_fifo_writer.sv
// Oversampling UART receiver that pushes each good byte into the async FIFO write port.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo_writer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                    WClk,
  input  logic                    WReset,
  input  logic                    Rx,
  uart_rx_fifo_writer_if.master   fifo,
  output logic                    Busy,
  output logic                    Frame_Err,
  output logic                    Overrun_Err
`ifdef UART_RX_PARITY_EN
  , output logic                  Parity_Err
`endif
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [TICK_W-1:0] HALF_M1  = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_M1   = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PUSH   = 3'd4
`ifdef UART_RX_PARITY_EN
    , ST_PARITY = 3'd5
`endif
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic                  rx_meta_r;
  logic                  rx_sync_r;
  logic                  rx_prev_r;
  logic [TICK_W-1:0]     tick_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] din_r;
  logic                  edge_pend_r;
  logic                  edge_s;
  logic                  sample_s;
  logic                  write_s;
  logic                  frame_err_s;
  logic                  overrun_err_s;
`ifdef UART_RX_PARITY_EN
  logic                  parity_bad_r;
  logic                  parity_err_s;
`endif

  assign edge_s = rx_prev_r & ~rx_sync_r;

  // FSM state register
  always_ff @(posedge WClk or posedge WReset) begin
    if (WReset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; sample points and output pulses are decided here
  always_comb begin
    next_state_s  = state_r;
    sample_s      = 1'b0;
    write_s       = 1'b0;
    frame_err_s   = 1'b0;
    overrun_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (edge_s || edge_pend_r) next_state_s = ST_START;
        else                       next_state_s = ST_IDLE;
      end
      ST_START: begin
        sample_s = (tick_r == HALF_M1);
        if (sample_s) begin
          if (rx_sync_r) next_state_s = ST_IDLE;
          else           next_state_s = ST_DATA;
        end else begin
          next_state_s = ST_START;
        end
      end
      ST_DATA: begin
        sample_s = (tick_r == BIT_M1);
        if (sample_s && (bit_cnt_r == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          next_state_s = ST_PARITY;
`else
          next_state_s = ST_STOP;
`endif
        end else begin
          next_state_s = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        sample_s = (tick_r == BIT_M1);
        if (sample_s) next_state_s = ST_STOP;
        else          next_state_s = ST_PARITY;
      end
`endif
      ST_STOP: begin
        sample_s = (tick_r == BIT_M1);
        if (!sample_s) begin
          next_state_s = ST_STOP;
`ifdef UART_RX_PARITY_EN
        end else if (parity_bad_r) begin
          parity_err_s = 1'b1;
          frame_err_s  = ~rx_sync_r;
          next_state_s = ST_IDLE;
`endif
        end else if (!rx_sync_r) begin
          frame_err_s  = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_PUSH;
        end
      end
      ST_PUSH: begin
        // Full is looked at only here, so a full FIFO never aborts a frame in flight
        write_s       = ~fifo.Full;
        overrun_err_s = fifo.Full;
        next_state_s  = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Synchronizer, bit timing, shift register and held output byte
  always_ff @(posedge WClk or posedge WReset) begin
    if (WReset) begin
      rx_meta_r    <= 1'b1;
      rx_sync_r    <= 1'b1;
      rx_prev_r    <= 1'b1;
      tick_r       <= '0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      din_r        <= '0;
      edge_pend_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_r <= 1'b0;
`endif
    end else begin
      rx_meta_r <= Rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;

      if ((state_r == ST_IDLE) || sample_s) tick_r <= '0;
      else                                  tick_r <= tick_r + TICK_W'(1);

      if (state_r != ST_DATA) bit_cnt_r <= '0;
      else if (sample_s)      bit_cnt_r <= bit_cnt_r + BIT_W'(1);

      if ((state_r == ST_DATA) && sample_s) shift_r <= {rx_sync_r, shift_r[DATA_WIDTH-1:1]};

      if (write_s) din_r <= shift_r;

      // A start edge seen during PUSH is remembered so the next frame starts from IDLE
      edge_pend_r <= (state_r == ST_PUSH) & edge_s;

`ifdef UART_RX_PARITY_EN
      if (state_r == ST_IDLE) begin
        parity_bad_r <= 1'b0;
      end else if ((state_r == ST_PARITY) && sample_s) begin
        parity_bad_r <= ((^shift_r) ^ rx_sync_r) != PARITY_ODD;
      end
`endif
    end
  end

  assign fifo.Write  = write_s;
  assign fifo.Din    = write_s ? shift_r : din_r;
  assign Busy        = (state_r != ST_IDLE);
  assign Frame_Err   = frame_err_s;
  assign Overrun_Err = overrun_err_s;
`ifdef UART_RX_PARITY_EN
  assign Parity_Err  = parity_err_s;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Self-checking bench for uart_rx_fifo_writer: table vectors, corner-case sequences and a randomized run.
`timescale 1ns/1ps
module tb_uart_rx_fifo_writer;

  localparam int CPB = 16;
  localparam int DW  = 8;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int STOP_T    = HALF + (DW + 1 + PB) * CPB;
  localparam int PUSH_T    = STOP_T + 1;
  localparam int FRAME_CYC = (DW + 2 + PB) * CPB;
  localparam int STOP_SHORT = PUSH_T - (DW + 1 + PB) * CPB;

  logic WClk = 1'b0;
  logic WReset;
  logic Rx;
  logic Busy;
  logic Frame_Err;
  logic Overrun_Err;
`ifdef UART_RX_PARITY_EN
  logic Parity_Err;
  logic par_flip_g = 1'b0;
`endif

  uart_rx_fifo_writer_if #(.DATA_WIDTH(DW)) fif ();

  uart_rx_fifo_writer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .WClk        (WClk),
    .WReset      (WReset),
    .Rx          (Rx),
    .fifo        (fif.master),
    .Busy        (Busy),
    .Frame_Err   (Frame_Err),
    .Overrun_Err (Overrun_Err)
`ifdef UART_RX_PARITY_EN
    , .Parity_Err (Parity_Err)
`endif
  );

  always #5 WClk = ~WClk;

  int unsigned cyc = 0;
  always @(posedge WClk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wr_data_q[$];
  int unsigned wr_cyc_q[$];
  int unsigned ferr_cyc_q[$];
  int unsigned ovr_cyc_q[$];
`ifdef UART_RX_PARITY_EN
  int unsigned perr_cyc_q[$];
`endif
  logic busy_h [32768];
  int  inv_viol = 0;
  bit  prev_wr = 1'b0;

  // Output monitor: logs events and Busy per cycle, flags illegal Write behaviour
  always @(negedge WClk) begin
    busy_h[cyc[14:0]] <= Busy;
    if (fif.Write === 1'b1) begin
      wr_data_q.push_back(fif.Din);
      wr_cyc_q.push_back(cyc);
      if (fif.Full !== 1'b0) inv_viol++;
      if (prev_wr) inv_viol++;
    end
    prev_wr <= (fif.Write === 1'b1);
    if (Frame_Err === 1'b1)   ferr_cyc_q.push_back(cyc);
    if (Overrun_Err === 1'b1) ovr_cyc_q.push_back(cyc);
`ifdef UART_RX_PARITY_EN
    if (Parity_Err === 1'b1)  perr_cyc_q.push_back(cyc);
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic busy_at(input int unsigned c);
    return busy_h[c[14:0]];
  endfunction

  task automatic expect_write(input string name, input int idx, input logic [7:0] d, input int unsigned c);
    if (idx < wr_data_q.size()) begin
      check({name, "_din"}, wr_data_q[idx], d);
      check({name, "_cyc"}, wr_cyc_q[idx], c);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: write #%0d missing, expected Din 0x%0h", name, idx, d);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    Rx = b;
    repeat (n) @(posedge WClk);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  // t0 is the cycle in which the DUT sees the start edge (two synchronizer stages later)
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int stop_len, output int unsigned t0);
    t0 = cyc + 2;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DW; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip_g, CPB);
`endif
    drive_bit(stop_b, stop_len);
  endtask

  task automatic at_cycle(input int unsigned target);
    if (target > cyc) repeat (target - cyc) @(posedge WClk);
    @(negedge WClk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic       full;
    int         exp_wr;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t        vecs[8];
  int unsigned t0, t1, t2;
  int          w0, f0, o0, nb;
  logic [7:0]  last_din;
  logic [7:0]  exp_data_q[$];
  int unsigned exp_cyc_q[$];
  int          exp_ferr, exp_ovr;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 0, 1, 0};
    vecs[2] = '{8'h5A, 1'b1, 1'b1, 0, 0, 1};
    vecs[3] = '{8'h11, 1'b1, 1'b0, 1, 0, 0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1, 0, 0};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1, 0, 0};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 0, 1, 0};
    vecs[7] = '{8'hC3, 1'b1, 1'b1, 0, 0, 1};

    WReset   = 1'b1;
    Rx       = 1'b1;
    fif.Full = 1'b0;
    repeat (2) @(negedge WClk);
    check("rst_write", fif.Write, 1'b0);
    check("rst_din", fif.Din, 8'h00);
    check("rst_busy", Busy, 1'b0);
    check("rst_frame_err", Frame_Err, 1'b0);
    check("rst_overrun_err", Overrun_Err, 1'b0);
    @(posedge WClk);
    #1 WReset = 1'b0;
    idle(3);

    // Table-driven single frames
    last_din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w0 = wr_data_q.size();
      f0 = ferr_cyc_q.size();
      o0 = ovr_cyc_q.size();
      fif.Full = vecs[i].full;
      send_frame(vecs[i].data, vecs[i].stop_b, CPB, t0);
      idle(4);
      fif.Full = 1'b0;
      check($sformatf("tbl%0d_wr_cnt", i), wr_data_q.size() - w0, vecs[i].exp_wr);
      check($sformatf("tbl%0d_ferr_cnt", i), ferr_cyc_q.size() - f0, vecs[i].exp_ferr);
      check($sformatf("tbl%0d_ovr_cnt", i), ovr_cyc_q.size() - o0, vecs[i].exp_ovr);
      if (vecs[i].exp_wr != 0) begin
        expect_write($sformatf("tbl%0d", i), w0, vecs[i].data, t0 + PUSH_T);
        last_din = vecs[i].data;
      end
      if ((vecs[i].exp_ferr != 0) && (ferr_cyc_q.size() > f0))
        check($sformatf("tbl%0d_ferr_cyc", i), ferr_cyc_q[f0], t0 + STOP_T);
      if ((vecs[i].exp_ovr != 0) && (ovr_cyc_q.size() > o0))
        check($sformatf("tbl%0d_ovr_cyc", i), ovr_cyc_q[o0], t0 + PUSH_T);
      check($sformatf("tbl%0d_busy_t0", i), busy_at(t0), 1'b0);
      check($sformatf("tbl%0d_busy_t1", i), busy_at(t0 + 1), 1'b1);
      check($sformatf("tbl%0d_busy_end", i), busy_at(t0 + PUSH_T + 1), 1'b0);
      check($sformatf("tbl%0d_din_hold", i), fif.Din, last_din);
    end

    // False start: line low for only 4 cycles
    w0 = wr_data_q.size();
    f0 = ferr_cyc_q.size();
    t0 = cyc + 2;
    drive_bit(1'b0, 4);
    idle(30);
    check("false_start_busy_t1", busy_at(t0 + 1), 1'b1);
    check("false_start_busy_off", busy_at(t0 + HALF + 1), 1'b0);
    check("false_start_wr", wr_data_q.size() - w0, 0);
    check("false_start_ferr", ferr_cyc_q.size() - f0, 0);

    // Framing error followed by a line held low: no retrigger until a fresh edge
    w0 = wr_data_q.size();
    f0 = ferr_cyc_q.size();
    send_frame(8'h3C, 1'b0, CPB, t0);
    drive_bit(1'b0, 40);
    idle(3);
    check("held_low_ferr_cnt", ferr_cyc_q.size() - f0, 1);
    if (ferr_cyc_q.size() > f0) check("held_low_ferr_cyc", ferr_cyc_q[f0], t0 + STOP_T);
    check("held_low_wr", wr_data_q.size() - w0, 0);
    nb = 0;
    for (int unsigned c = t0 + STOP_T + 1; c <= t0 + FRAME_CYC + 40; c++) nb += int'(busy_at(c));
    check("held_low_no_retrigger", nb, 0);
    send_frame(8'h99, 1'b1, CPB, t0);
    idle(4);
    expect_write("after_held_low", w0, 8'h99, t0 + PUSH_T);

    // Back-to-back frames with no idle gap
    w0 = wr_data_q.size();
    send_frame(8'h01, 1'b1, CPB, t0);
    send_frame(8'hFF, 1'b1, CPB, t1);
    send_frame(8'h80, 1'b1, CPB, t2);
    idle(4);
    check("b2b_wr_cnt", wr_data_q.size() - w0, 3);
    expect_write("b2b0", w0,     8'h01, t0 + PUSH_T);
    expect_write("b2b1", w0 + 1, 8'hFF, t1 + PUSH_T);
    expect_write("b2b2", w0 + 2, 8'h80, t2 + PUSH_T);

    // Shortened stop bit so the next start edge lands exactly in the PUSH cycle
    w0 = wr_data_q.size();
    send_frame(8'hC9, 1'b1, STOP_SHORT, t0);
    send_frame(8'h36, 1'b1, CPB, t1);
    idle(4);
    check("push_edge_wr_cnt", wr_data_q.size() - w0, 2);
    expect_write("push_edge0", w0,     8'hC9, t0 + PUSH_T);
    expect_write("push_edge1", w0 + 1, 8'h36, t0 + PUSH_T + 1 + PUSH_T);

    // Asynchronous reset in the middle of a frame
    w0 = wr_data_q.size();
    t0 = cyc + 2;
    fork
      send_frame(8'h77, 1'b1, CPB, t1);
      begin
        at_cycle(t0 + 70);
        #1 WReset = 1'b1;
        #1;
        check("rst_mid_busy", Busy, 1'b0);
        check("rst_mid_write", fif.Write, 1'b0);
        check("rst_mid_din", fif.Din, 8'h00);
        check("rst_mid_frame_err", Frame_Err, 1'b0);
        check("rst_mid_overrun_err", Overrun_Err, 1'b0);
      end
    join
    WReset = 1'b0;
    check("rst_mid_was_busy", busy_at(t0 + 69), 1'b1);
    idle(3);
    send_frame(8'h42, 1'b1, CPB, t0);
    idle(4);
    check("rst_mid_wr_cnt", wr_data_q.size() - w0, 1);
    expect_write("after_rst", w0, 8'h42, t0 + PUSH_T);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs a parity bit of 1
    w0 = wr_data_q.size();
    f0 = perr_cyc_q.size();
    par_flip_g = 1'b1;
    send_frame(8'h07, 1'b1, CPB, t0);
    par_flip_g = 1'b0;
    idle(4);
    check("parity_bad_perr_cnt", perr_cyc_q.size() - f0, 1);
    if (perr_cyc_q.size() > f0) check("parity_bad_perr_cyc", perr_cyc_q[f0], t0 + STOP_T);
    check("parity_bad_wr", wr_data_q.size() - w0, 0);
    send_frame(8'h07, 1'b1, CPB, t0);
    idle(4);
    expect_write("parity_good", w0, 8'h07, t0 + PUSH_T);
    check("parity_good_perr", perr_cyc_q.size() - f0, 1);
`endif

    // Randomized frames against the frame-level reference model
    w0 = wr_data_q.size();
    f0 = ferr_cyc_q.size();
    o0 = ovr_cyc_q.size();
    exp_ferr = 0;
    exp_ovr  = 0;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       full, serr;
      int         gap;
      d    = 8'($urandom_range(0, 255));
      full = ($urandom_range(0, 3) == 0);
      serr = ($urandom_range(0, 7) == 0);
      gap  = int'($urandom_range(0, 20));
      fif.Full = full;
      send_frame(d, ~serr, CPB, t0);
      if (serr) begin
        exp_ferr++;
        if (gap < 2) gap = 2;
      end else if (full) begin
        exp_ovr++;
      end else begin
        exp_data_q.push_back(d);
        exp_cyc_q.push_back(t0 + PUSH_T);
      end
      idle(gap);
    end
    idle(4);
    fif.Full = 1'b0;
    check("rand_wr_cnt", wr_data_q.size() - w0, exp_data_q.size());
    check("rand_ferr_cnt", ferr_cyc_q.size() - f0, exp_ferr);
    check("rand_ovr_cnt", ovr_cyc_q.size() - o0, exp_ovr);
    for (int i = 0; i < exp_data_q.size(); i++)
      expect_write($sformatf("rand%0d", i), w0 + i, exp_data_q[i], exp_cyc_q[i]);

    check("write_invariants", inv_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
